// File: rtl/modulo_demux_varredura.sv
// Registered 1-to-N demultiplexer with manual select or timed scan of all channels.
// Channel k drives out[N_CANAIS-1-k], so channel 0 sits on the MSB.
module modulo_demux_varredura #(
   parameter int N_CANAIS = 35,
   parameter int SEL_W    = 6,
   parameter int DWELL    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                A,
   input  logic                modo,
   input  logic                enable,
   input  logic [SEL_W-1:0]    input_sel,
   output logic [N_CANAIS-1:0] out,
   output logic [SEL_W-1:0]    canal_atual,
   output logic                sel_invalido,
   output logic                fim_varredura
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0] ULTIMO    = SEL_W'(N_CANAIS - 1);
   localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL - 1);

   typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [DW_W-1:0]     dwell_q, dwell_d;
   logic [SEL_W-1:0]    canal_d;
   logic [N_CANAIS-1:0] out_d;
   logic                inv_d, fim_d, drive;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= MANUAL;
         dwell_q       <= '0;
         canal_atual   <= '0;
         out           <= '0;
         sel_invalido  <= 1'b0;
         fim_varredura <= 1'b0;
      end else begin
         state_q       <= state_d;
         dwell_q       <= dwell_d;
         canal_atual   <= canal_d;
         out           <= out_d;
         sel_invalido  <= inv_d;
         fim_varredura <= fim_d;
      end
   end

   always_comb begin
      state_d = modo ? SCAN : MANUAL;
      dwell_d = dwell_q;
      canal_d = canal_atual;
      inv_d   = 1'b0;
      fim_d   = 1'b0;
      drive   = 1'b1;
      out_d   = '0;

      if (!modo) begin
         // Manual select; an out-of-range index blanks the outputs but keeps the channel.
         dwell_d = '0;
         if (input_sel <= ULTIMO) begin
            canal_d = input_sel;
         end else begin
            inv_d = 1'b1;
            drive = 1'b0;
         end
      end else if (state_q == MANUAL) begin
         canal_d = '0;
         dwell_d = '0;
      end else if (enable) begin
         if (dwell_q == DWELL_MAX) begin
            dwell_d = '0;
            if (canal_atual == ULTIMO) begin
               canal_d = '0;
               fim_d   = 1'b1;
            end else begin
               canal_d = canal_atual + 1'b1;
            end
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
      end

      for (int unsigned k = 0; k < N_CANAIS; k++) begin
         if (drive && canal_d == SEL_W'(k)) out_d[N_CANAIS-1-k] = A;
      end
   end

endmodule

// File: tb/tb_modulo_demux_varredura.sv
// Directed bench for modulo_demux_varredura: default 35-channel instance plus two small parameter sets.
module tb_modulo_demux_varredura;

   logic        clk = 1'b0;
   logic        reset;
   logic        a0, modo0, en0;
   logic [5:0]  sel0;
   logic [34:0] out0;
   logic [5:0]  canal0;
   logic        inv0, fim0;

   logic        a1, modo1, en1;
   logic [2:0]  sel1;
   logic [7:0]  out1;
   logic [2:0]  canal1;
   logic        inv1, fim1;

   logic        a2, modo2, en2;
   logic [2:0]  sel2;
   logic [4:0]  out2;
   logic [2:0]  canal2;
   logic        inv2, fim2;

   int checks = 0;
   int errors = 0;
   int fim_count;
   int exp_c;

   always #5 clk = ~clk;

   modulo_demux_varredura dut (
      .clk(clk), .reset(reset), .A(a0), .modo(modo0), .enable(en0), .input_sel(sel0),
      .out(out0), .canal_atual(canal0), .sel_invalido(inv0), .fim_varredura(fim0));

   modulo_demux_varredura #(.N_CANAIS(8), .SEL_W(3), .DWELL(1)) dut8 (
      .clk(clk), .reset(reset), .A(a1), .modo(modo1), .enable(en1), .input_sel(sel1),
      .out(out1), .canal_atual(canal1), .sel_invalido(inv1), .fim_varredura(fim1));

   modulo_demux_varredura #(.N_CANAIS(5), .SEL_W(3), .DWELL(4)) dut5 (
      .clk(clk), .reset(reset), .A(a2), .modo(modo2), .enable(en2), .input_sel(sel2),
      .out(out2), .canal_atual(canal2), .sel_invalido(inv2), .fim_varredura(fim2));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] onehot(input int bitpos);
      logic [63:0] v;
      v = 64'd1;
      return v << bitpos;
   endfunction

   initial begin
      reset = 1'b1;
      a0 = 1'b0; modo0 = 1'b0; en0 = 1'b0; sel0 = '0;
      a1 = 1'b1; modo1 = 1'b0; en1 = 1'b1; sel1 = '0;
      a2 = 1'b1; modo2 = 1'b0; en2 = 1'b0; sel2 = '0;
      step();
      step();
      check("rst_out", 64'(out0), 64'd0);
      check("rst_canal", 64'(canal0), 64'd0);
      check("rst_inv", 64'(inv0), 64'd0);
      check("rst_fim", 64'(fim0), 64'd0);
      reset = 1'b0;

      a0 = 1'b1;
      for (int s = 0; s < 35; s++) begin
         sel0 = 6'(s);
         step();
         check("man_out", 64'(out0), onehot(34 - s));
         check("man_canal", 64'(canal0), 64'(s));
         check("man_inv", 64'(inv0), 64'd0);
      end
      a0 = 1'b0; sel0 = 6'd10;
      step();
      check("man_a0_out", 64'(out0), 64'd0);
      check("man_a0_canal", 64'(canal0), 64'd10);

      a0 = 1'b1; sel0 = 6'd34;
      step();
      sel0 = 6'd35;
      step();
      check("inv35_out", 64'(out0), 64'd0);
      check("inv35_flag", 64'(inv0), 64'd1);
      check("inv35_canal", 64'(canal0), 64'd34);
      sel0 = 6'd63;
      step();
      check("inv63_out", 64'(out0), 64'd0);
      check("inv63_flag", 64'(inv0), 64'd1);
      check("inv63_canal", 64'(canal0), 64'd34);
      sel0 = 6'd5;
      step();
      check("sel5_flag", 64'(inv0), 64'd0);
      check("sel5_out", 64'(out0), onehot(29));

      // Full sweep: entry edge is cycle 0, wrap happens on cycle 140.
      modo0 = 1'b1; en0 = 1'b1; sel0 = 6'd40;
      step();
      check("scan0_canal", 64'(canal0), 64'd0);
      check("scan0_out", 64'(out0), onehot(34));
      check("scan0_inv", 64'(inv0), 64'd0);
      fim_count = 0;
      for (int c = 1; c <= 140; c++) begin
         step();
         exp_c = (c / 4) % 35;
         check("scan_canal", 64'(canal0), 64'(exp_c));
         check("scan_out", 64'(out0), onehot(34 - exp_c));
         check("scan_fim", 64'(fim0), 64'(c == 140));
         if (fim0) fim_count++;
      end
      check("scan_fim_count", 64'(fim_count), 64'd1);

      // Reach channel 7 one cycle into its dwell, then pause.
      for (int c = 0; c < 29; c++) step();
      check("pause_pre", 64'(canal0), 64'd7);
      en0 = 1'b0;
      for (int c = 0; c < 10; c++) begin
         a0 = c[0];
         step();
         check("pause_canal", 64'(canal0), 64'd7);
         check("pause_out", 64'(out0), 64'(c[0]) << 27);
         check("pause_fim", 64'(fim0), 64'd0);
      end
      a0 = 1'b1; en0 = 1'b1;
      step();
      check("resume1", 64'(canal0), 64'd7);
      step();
      check("resume2", 64'(canal0), 64'd7);
      step();
      check("resume3", 64'(canal0), 64'd8);
      check("resume3_out", 64'(out0), onehot(26));

      for (int c = 0; c < 48; c++) step();
      check("pre_rst_canal", 64'(canal0), 64'd20);
      reset = 1'b1;
      step();
      check("mid_rst_out", 64'(out0), 64'd0);
      check("mid_rst_canal", 64'(canal0), 64'd0);
      check("mid_rst_fim", 64'(fim0), 64'd0);
      check("mid_rst_state", 64'(dut.state_q), 64'd0);
      reset = 1'b0;

      // Leave scan on the very edge that would wrap: no pulse, manual load wins.
      step();
      check("re_scan_canal", 64'(canal0), 64'd0);
      for (int c = 0; c < 139; c++) step();
      check("last_canal", 64'(canal0), 64'd34);
      modo0 = 1'b0; sel0 = 6'd2;
      step();
      check("wrap_exit_fim", 64'(fim0), 64'd0);
      check("wrap_exit_canal", 64'(canal0), 64'd2);
      check("wrap_exit_out", 64'(out0), onehot(32));

      // 8 channels, DWELL=1: advance every cycle, pulse every 8th.
      modo1 = 1'b1;
      step();
      check("d8_entry", 64'(canal1), 64'd0);
      for (int c = 1; c <= 24; c++) begin
         step();
         check("d8_canal", 64'(canal1), 64'(c % 8));
         check("d8_out", 64'(out1), onehot(7 - (c % 8)));
         check("d8_fim", 64'(fim1), 64'((c % 8) == 0));
      end

      sel2 = 3'd6;
      step();
      check("n5_inv", 64'(inv2), 64'd1);
      check("n5_inv_out", 64'(out2), 64'd0);
      sel2 = 3'd4;
      step();
      check("n5_ok_inv", 64'(inv2), 64'd0);
      check("n5_ok_out", 64'(out2), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
